// File: rtl/fir_pkg.sv
// Shared constants, default coefficient set and controller state type for the
// folded 37-tap symmetric FIR.
package fir_pkg;

    localparam int WL       = 14;
    localparam int FOLD_LEN = 19;
    localparam int TAP_NUM  = 37;
    localparam int MAC_WL   = 20;

    // Unique folded taps, index 0 (outermost) to 18 (centre tap)
    localparam int DEFAULT_COEF [FOLD_LEN] = '{
        -19, -68, 0, 120, 60, -166, -176, 169, 344, -89,
        -557, -134, 781, 592, -982, -1588, 1120, 5819, 8191
    };

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/fir_coef_bank.sv
// DEPTH x W coefficient register file: single-word write, parallel load from a
// flat bus, flat read-out of every word, and asynchronous reset to the default set.
module fir_coef_bank import fir_pkg::*; #(
    parameter int unsigned W     = 14,
    parameter int unsigned DEPTH = 19,
    parameter int unsigned AW    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [W-1:0]       wr_data,
    input  logic               load_en,
    input  logic [DEPTH*W-1:0] load_data,
    output logic [DEPTH*W-1:0] data_flat
);

    logic [W-1:0] mem [DEPTH];

    // Parallel load takes priority over the single-word write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= W'(DEFAULT_COEF[i]);
            end
        end else if (load_en) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= load_data[i*W +: W];
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        data_flat = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            data_flat[i*W +: W] = mem[i];
        end
    end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Shadow/active coefficient controller: host writes go to the shadow bank, and a
// commit copies shadow to active only on a sample boundary.
module fir_coef_ctrl import fir_pkg::*; #(
    parameter int WL       = 14,
    parameter int FOLD_LEN = 19,
    parameter int ADDR_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_wr_en,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic [WL-1:0]          cfg_wdata,
    input  logic [ADDR_W-1:0]      cfg_rd_addr,
    output logic [WL-1:0]          cfg_rdata,
    input  logic                   cfg_commit,
    input  logic                   sample_stb,
    output logic [FOLD_LEN*WL-1:0] coef_flat,
    output logic                   cfg_busy,
    output logic                   commit_done,
    output logic                   cfg_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FOLD_LEN - 1);

    cfg_state_e state, state_nxt;
    logic       copy_now;
    logic       wr_accept;
    logic       wr_bad;
    logic [FOLD_LEN*WL-1:0] shadow_flat;
    logic [WL-1:0]          rd_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A commit seen in IDLE always waits for a later strobe, even if one is
    // present in the same cycle, so arming lasts at least one full sample.
    always_comb begin
        state_nxt = state;
        copy_now  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_commit) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (sample_stb) begin
                    copy_now  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cfg_busy  = (state == ARMED);
    assign wr_accept = cfg_wr_en && (state == IDLE) && (cfg_addr <= LAST_ADDR);
    assign wr_bad    = cfg_wr_en && !wr_accept;

    fir_coef_bank #(
        .W     (WL),
        .DEPTH (FOLD_LEN),
        .AW    (ADDR_W)
    ) u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_accept),
        .wr_addr   (cfg_addr),
        .wr_data   (cfg_wdata),
        .load_en   (1'b0),
        .load_data ('0),
        .data_flat (shadow_flat)
    );

    fir_coef_bank #(
        .W     (WL),
        .DEPTH (FOLD_LEN),
        .AW    (ADDR_W)
    ) u_active (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (1'b0),
        .wr_addr   ('0),
        .wr_data   ('0),
        .load_en   (copy_now),
        .load_data (shadow_flat),
        .data_flat (coef_flat)
    );

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < FOLD_LEN; i++) begin
            if (cfg_rd_addr == ADDR_W'(i)) begin
                rd_word = shadow_flat[i*WL +: WL];
            end
        end
    end

    // A bad write in the acknowledging commit cycle still leaves the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_rdata   <= '0;
            commit_done <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_rdata   <= rd_word;
            commit_done <= copy_now;
            if (wr_bad) begin
                cfg_err <= 1'b1;
            end else if ((state == IDLE) && cfg_commit) begin
                cfg_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: table-driven write/readback vectors plus
// hand-written commit, error and reset-while-armed sequences.
module tb_fir_coef_ctrl;

    localparam int WL       = 14;
    localparam int FOLD_LEN = 19;
    localparam int ADDR_W   = 5;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   cfg_wr_en;
    logic [ADDR_W-1:0]      cfg_addr;
    logic [WL-1:0]          cfg_wdata;
    logic [ADDR_W-1:0]      cfg_rd_addr;
    logic [WL-1:0]          cfg_rdata;
    logic                   cfg_commit;
    logic                   sample_stb;
    logic [FOLD_LEN*WL-1:0] coef_flat;
    logic                   cfg_busy;
    logic                   commit_done;
    logic                   cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    fir_coef_ctrl #(
        .WL       (WL),
        .FOLD_LEN (FOLD_LEN),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rd_addr (cfg_rd_addr),
        .cfg_rdata   (cfg_rdata),
        .cfg_commit  (cfg_commit),
        .sample_stb  (sample_stb),
        .coef_flat   (coef_flat),
        .cfg_busy    (cfg_busy),
        .commit_done (commit_done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  wr_en;
        int    addr;
        int    wdata;
        int    rd_addr;
        int    exp_rdata;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int tap(input int k);
        logic signed [WL-1:0] t;
        t = coef_flat[k*WL +: WL];
        return int'(t);
    endfunction

    function automatic int rdata_s();
        logic signed [WL-1:0] t;
        t = cfg_rdata;
        return int'(t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_wr_en   = 1'b0;
        cfg_addr    = '0;
        cfg_wdata   = '0;
        cfg_commit  = 1'b0;
        sample_stb  = 1'b0;
    endtask

    initial begin
        vt[0] = '{"rd_def0",    1'b0,  0,     0,  0,   -19};
        vt[1] = '{"rd_def9",    1'b0,  0,     0,  9,   -89};
        vt[2] = '{"rd_def18",   1'b0,  0,     0, 18,  8191};
        vt[3] = '{"rd_oob25",   1'b0,  0,     0, 25,     0};
        vt[4] = '{"wr3_m500",   1'b1,  3,  -500,  3,  -500};
        vt[5] = '{"wr18_min",   1'b1, 18, -8192, 18, -8192};
        vt[6] = '{"wr18_max",   1'b1, 18,  8191, 18,  8191};
        vt[7] = '{"rd_def16",   1'b0,  0,     0, 16,  1120};

        idle_inputs();
        cfg_rd_addr = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tap0_raw", int'(coef_flat[0 +: WL]), 14'h3FED);
        check("rst_tap0",    tap(0),  -19);
        check("rst_tap17",   tap(17), 5819);
        check("rst_tap18",   tap(18), 8191);
        check("rst_rdata",   int'(cfg_rdata), 0);
        check("rst_busy",    int'(cfg_busy), 0);
        check("rst_done",    int'(commit_done), 0);
        check("rst_err",     int'(cfg_err), 0);
        rst_n = 1'b1;
        tick();

        // Write (if any) in one cycle, then read back with one-cycle latency
        for (int i = 0; i < 8; i++) begin
            cfg_wr_en = vt[i].wr_en;
            cfg_addr  = ADDR_W'(vt[i].addr);
            cfg_wdata = WL'(vt[i].wdata);
            tick();
            cfg_wr_en   = 1'b0;
            cfg_rd_addr = ADDR_W'(vt[i].rd_addr);
            tick();
            check(vt[i].name, rdata_s(), vt[i].exp_rdata);
        end
        check("pre_commit_tap3", tap(3), 120);
        check("table_err", int'(cfg_err), 0);

        // Commit, four idle cycles, then the strobe
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("armed_busy", int'(cfg_busy), 1);
            check("armed_tap3_old", tap(3), 120);
            tick();
        end
        check("armed_busy_stb", int'(cfg_busy), 1);
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        check("commit_tap3", tap(3), -500);
        check("commit_done_pulse", int'(commit_done), 1);
        check("commit_busy_clr", int'(cfg_busy), 0);
        tick();
        check("commit_done_low", int'(commit_done), 0);

        // Write + commit + strobe in one IDLE cycle: arms only, write included
        cfg_wr_en  = 1'b1;
        cfg_addr   = ADDR_W'(5);
        cfg_wdata  = WL'(1234);
        cfg_commit = 1'b1;
        sample_stb = 1'b1;
        tick();
        idle_inputs();
        check("same_cyc_busy", int'(cfg_busy), 1);
        check("same_cyc_tap5_old", tap(5), -166);
        check("same_cyc_no_done", int'(commit_done), 0);
        check("same_cyc_err", int'(cfg_err), 0);
        tick();
        check("same_cyc_tap5_wait", tap(5), -166);
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        check("same_cyc_tap5_new", tap(5), 1234);
        check("same_cyc_done", int'(commit_done), 1);

        // Error handling
        cfg_wr_en = 1'b1;
        cfg_addr  = ADDR_W'(25);
        cfg_wdata = WL'(5);
        tick();
        cfg_wr_en = 1'b0;
        check("err_oob_addr", int'(cfg_err), 1);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check("err_clr_commit", int'(cfg_err), 0);
        check("err_armed_busy", int'(cfg_busy), 1);
        cfg_wr_en = 1'b1;
        cfg_addr  = ADDR_W'(0);
        cfg_wdata = WL'(77);
        tick();
        cfg_wr_en = 1'b0;
        check("err_wr_armed", int'(cfg_err), 1);
        cfg_rd_addr = ADDR_W'(0);
        tick();
        check("err_shadow0_frozen", rdata_s(), -19);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check("err_commit_armed_keep", int'(cfg_err), 1);
        check("err_commit_armed_busy", int'(cfg_busy), 1);
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        check("err_commit_done", int'(commit_done), 1);
        check("err_tap0", tap(0), -19);
        check("err_busy_after", int'(cfg_busy), 0);
        tick();
        check("err_done_single", int'(commit_done), 0);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check("err_ack_clear", int'(cfg_err), 0);
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        check("err_ack_done", int'(commit_done), 1);
        tick();

        // Reset while armed
        cfg_wr_en = 1'b1;
        cfg_addr  = ADDR_W'(10);
        cfg_wdata = WL'(1000);
        tick();
        cfg_wr_en  = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check("rst_armed_busy", int'(cfg_busy), 1);
        rst_n = 1'b0;
        #3;
        check("rst_armed_tap10", tap(10), -557);
        check("rst_armed_tap3", tap(3), 120);
        check("rst_armed_idle", int'(cfg_busy), 0);
        check("rst_armed_done", int'(commit_done), 0);
        tick();
        rst_n = 1'b1;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        check("post_rst_no_done", int'(commit_done), 0);
        check("post_rst_tap10", tap(10), -557);
        check("post_rst_busy", int'(cfg_busy), 0);
        cfg_rd_addr = ADDR_W'(10);
        tick();
        check("post_rst_shadow10", rdata_s(), -557);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
